// File: rtl/axil_reg_bank_pkg.sv
// axil_reg_bank_pkg: response codes and FSM state types for the AXI4-Lite register bank
package axil_reg_bank_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axil_strb_merge.sv
// axil_strb_merge: byte-lane merge, each lane takes new_i where strb_i is set, else old_i
//   old_i/new_i [DW] data words, strb_i [DW/8] lane enables, merged_o [DW] result
module axil_strb_merge
  import axil_reg_bank_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_i,
  input  logic [DW-1:0]   new_i,
  input  logic [DW/8-1:0] strb_i,
  output logic [DW-1:0]   merged_o
);
  for (genvar b = 0; b < DW / 8; b++) begin : g_lane
    assign merged_o[b*8 +: 8] = strb_i[b] ? new_i[b*8 +: 8] : old_i[b*8 +: 8];
  end
endmodule

// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite slave bank of NUM_REGS word registers with byte strobes and read-only status slots
//   S_AXI_*   AXI4-Lite slave (AW/W/B write, AR/R read), async active-high reset S_AXI_ARESET
//   ctrl_regs flattened register contents, wr_pulse one-cycle per-register write strobe
//   status_in read-only sources returned for indices flagged in RO_MASK
module axil_reg_bank
  import axil_reg_bank_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          NUM_REGS           = 8,
  parameter logic [63:0] RO_MASK            = 64'd0,
  localparam int         C_S_AXI_ADDR_WIDTH = $clog2(NUM_REGS) + $clog2(C_S_AXI_DATA_WIDTH / 8) + 1
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_REGS-1:0]                    wr_pulse,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in
);
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int LSB = $clog2(DW / 8);
  localparam int IW  = C_S_AXI_ADDR_WIDTH - LSB;
  localparam logic [IW-1:0]       N_IDX = IW'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] RO    = RO_MASK[NUM_REGS-1:0];
  w_state_t            ws_q, ws_d;
  r_state_t            rs_q, rs_d;
  logic                aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [IW-1:0]       widx_q, widx_d, ridx;
  logic [DW-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DW/8-1:0]     wstrb_q, wstrb_d;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wsel;
  logic [DW-1:0]       wold, wnew, rsel;
  logic                w_ro, w_in, r_in, commit, wr_en;
  logic                unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};
  assign ridx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
  assign w_in = widx_q < N_IDX;
  assign r_in = ridx < N_IDX;
  // READY is gated by reset so the bus sees 0 while reset is held, not just the idle state
  assign S_AXI_AWREADY = !S_AXI_ARESET && ws_q == W_IDLE && !aw_got_q;
  assign S_AXI_WREADY  = !S_AXI_ARESET && ws_q == W_IDLE && !w_got_q;
  assign S_AXI_ARREADY = !S_AXI_ARESET && rs_q == R_IDLE;
  assign S_AXI_BVALID  = ws_q == W_RESP;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rs_q == R_DATA;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;
  // both halves of the write are held in capture registers; the commit happens on the edge after both are present
  assign commit = ws_q == W_IDLE && aw_got_q && w_got_q;
  assign wr_en  = commit && w_in && !w_ro && |wstrb_q;
  always_comb begin
    wsel = '0;
    wold = '0;
    rsel = '0;
    w_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wsel[i] = widx_q == IW'(i);
      if (wsel[i]) begin
        wold = regs_q[i];
        w_ro = RO[i];
      end
      if (ridx == IW'(i)) rsel = RO[i] ? status_in[i*DW +: DW] : regs_q[i];
    end
  end
  axil_strb_merge #(.DW(DW)) u_merge (
    .old_i   (wold),
    .new_i   (wdata_q),
    .strb_i  (wstrb_q),
    .merged_o(wnew)
  );
  always_comb begin
    ws_d     = ws_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    if (ws_q == W_IDLE) begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_got_d = 1'b1;
        widx_d   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_got_d = 1'b1;
        wdata_d = S_AXI_WDATA;
        wstrb_d = S_AXI_WSTRB;
      end
      if (commit) begin
        ws_d    = W_RESP;
        bresp_d = !w_in ? RESP_DECERR : w_ro ? RESP_SLVERR : RESP_OKAY;
      end
    end else if (S_AXI_BREADY) begin
      ws_d     = W_IDLE;
      aw_got_d = 1'b0;
      w_got_d  = 1'b0;
    end
  end
  // read data is sampled from the pre-edge register state, so a same-cycle write is not visible
  always_comb begin
    rs_d    = rs_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (rs_q == R_IDLE && S_AXI_ARVALID) begin
      rs_d    = R_DATA;
      rdata_d = r_in ? rsel : '0;
      rresp_d = r_in ? RESP_OKAY : RESP_DECERR;
    end else if (rs_q == R_DATA && S_AXI_RREADY) begin
      rs_d = R_IDLE;
    end
  end
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      ws_q       <= W_IDLE;
      rs_q       <= R_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      widx_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      ws_q       <= ws_d;
      rs_q       <= rs_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      widx_q     <= widx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_en ? wsel : '0;
      for (int i = 0; i < NUM_REGS; i++) if (wr_en && wsel[i]) regs_q[i] <= wnew;
    end
  end
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
    assign ctrl_regs[r*DW +: DW] = regs_q[r];
  end
endmodule

// File: tb/tb_axil_reg_bank.sv
// tb_axil_reg_bank: directed self-checking bench; dut0 all-writable, dut1 with register 1 read-only
module tb_axil_reg_bank;
  logic         clk = 1'b0, rst = 1'b0;
  logic [5:0]   awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic [255:0] status_in = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic         awready1, wready1, bvalid1, arready1, rvalid1;
  logic [1:0]   bresp, rresp, bresp1, rresp1;
  logic [31:0]  rdata, rdata1;
  logic [255:0] ctrl_regs, ctrl_regs1;
  logic [7:0]   wr_pulse, wr_pulse1;
  int           checks = 0, errors = 0, pulses0 = 0, pulses1 = 0;
  axil_reg_bank dut0 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_regs(ctrl_regs), .wr_pulse(wr_pulse), .status_in(status_in)
  );
  axil_reg_bank #(.RO_MASK(64'h2)) dut1 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready1),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready1),
    .S_AXI_BRESP(bresp1), .S_AXI_BVALID(bvalid1), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready1),
    .S_AXI_RDATA(rdata1), .S_AXI_RRESP(rresp1), .S_AXI_RVALID(rvalid1), .S_AXI_RREADY(rready),
    .ctrl_regs(ctrl_regs1), .wr_pulse(wr_pulse1), .status_in(status_in)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    pulses0 += $countones(wr_pulse);
    pulses1 += $countones(wr_pulse1);
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [1:0] r0, output logic [1:0] r1);
    int   n = 0;
    logic ha, hw;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      ha = awvalid && awready;
      hw = wvalid && wready;
      @(negedge clk);
      n++;
      if (ha) awvalid = 1'b0;
      if (hw) wvalid = 1'b0;
    end
    if (awvalid || wvalid) chk("aw_w_timeout", 0, 1);
    awvalid = 1'b0; wvalid = 1'b0; n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) chk("b_timeout", 0, 1);
    r0 = bresp; r1 = bresp1; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask
  task automatic axi_rd(input logic [5:0] a, output logic [31:0] d0, output logic [1:0] r0,
                        output logic [31:0] d1, output logic [1:0] r1);
    int   n = 0;
    logic h;
    araddr = a; arvalid = 1'b1;
    while (arvalid && n < 20) begin
      h = arready;
      @(negedge clk);
      n++;
      if (h) arvalid = 1'b0;
    end
    if (arvalid) chk("ar_timeout", 0, 1);
    arvalid = 1'b0; n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) chk("r_timeout", 0, 1);
    d0 = rdata; r0 = rresp; d1 = rdata1; r1 = rresp1; rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask
  initial begin
    logic [1:0]  r0, r1, rr0, rr1;
    logic [31:0] d0, d1;
    int          p0, p1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {awready, wready, arready, awready1, wready1, arready1}, 0);
    chk("rst_valid", {bvalid, rvalid, bresp, rresp, rdata}, 0);
    chk("rst_regs", {ctrl_regs, wr_pulse}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {awready, wready, arready}, 3'b111);
    p0 = pulses0;
    for (int i = 0; i < 4; i++) begin
      axi_wr(6'(i * 4), 32'(i + 1), 4'hF, r0, r1);
      chk("wr_resp", r0, 2'b00);
    end
    chk("wr_pulses", pulses0 - p0, 4);
    for (int i = 0; i < 4; i++) begin
      axi_rd(6'(i * 4), d0, rr0, d1, rr1);
      chk("rd_data", d0, 32'(i + 1));
      chk("rd_resp", rr0, 2'b00);
    end
    chk("ctrl_regs", ctrl_regs[127:0], {32'd4, 32'd3, 32'd2, 32'd1});
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("w_first_ready", {wready, awready}, 2'b01);
    repeat (2) @(negedge clk);
    chk("w_no_commit", {bvalid, wr_pulse, ctrl_regs[63:32]}, {1'b0, 8'h00, 32'd2});
    awaddr = 6'h4; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("aw_edge", {bvalid, wr_pulse, ctrl_regs[63:32]}, {1'b0, 8'h00, 32'd2});
    @(negedge clk);
    chk("commit", {bvalid, bresp, wr_pulse, ctrl_regs[63:32]}, {1'b1, 2'b00, 8'h02, 32'hDEADBEEF});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("b_hold", {bvalid, bresp, wr_pulse}, {1'b1, 2'b00, 8'h00});
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_done", bvalid, 0);
    axi_rd(6'h4, d0, rr0, d1, rr1);
    chk("rd_deadbeef", d0, 32'hDEADBEEF);
    axi_wr(6'h8, 32'h12345678, 4'hF, r0, r1);
    axi_wr(6'h8, 32'hFFFFFFFF, 4'b0101, r0, r1);
    chk("strb_resp", r0, 2'b00);
    axi_rd(6'h8, d0, rr0, d1, rr1);
    chk("strb_data", d0, 32'h12FF56FF);
    p0 = pulses0;
    axi_wr(6'h8, 32'hAAAAAAAA, 4'h0, r0, r1);
    chk("strb0_resp", r0, 2'b00);
    chk("strb0_pulse", pulses0 - p0, 0);
    axi_rd(6'h8, d0, rr0, d1, rr1);
    chk("strb0_data", d0, 32'h12FF56FF);
    fork
      axi_wr(6'h0, 32'h55, 4'hF, r0, r1);
      axi_rd(6'h0, d0, rr0, d1, rr1);
    join
    chk("rw_old", {d0, rr0, r0}, {32'd1, 2'b00, 2'b00});
    axi_rd(6'h0, d0, rr0, d1, rr1);
    chk("rw_new", d0, 32'h55);
    status_in[63:32] = 32'hCAFE0001;
    p1 = pulses1;
    axi_wr(6'h4, 32'h11111111, 4'hF, r0, r1);
    chk("ro_bresp", {r1, r0}, {2'b10, 2'b00});
    chk("ro_pulse", pulses1 - p1, 0);
    chk("ro_reg", ctrl_regs1[63:32], 0);
    axi_rd(6'h4, d0, rr0, d1, rr1);
    chk("ro_read", {d1, rr1}, {32'hCAFE0001, 2'b00});
    chk("rw_read", {d0, rr0}, {32'h11111111, 2'b00});
    p0 = pulses0;
    axi_wr(6'h20, 32'h99, 4'hF, r0, r1);
    chk("oor_bresp", {r0, r1}, 4'hF);
    chk("oor_pulse", pulses0 - p0, 0);
    axi_rd(6'h20, d0, rr0, d1, rr1);
    chk("oor_read", {d0, rr0}, {32'd0, 2'b11});
    chk("oor_regs", ctrl_regs, {128'd0, 32'd4, 32'h12FF56FF, 32'h11111111, 32'h55});
    awaddr = 6'hC; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("aw_captured", {awready, wready}, 2'b01);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, wr_pulse}, 0);
    chk("mid_rst_regs", ctrl_regs, 0);
    @(negedge clk);
    rst = 1'b0;
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("stale_aw", {bvalid, wr_pulse, ctrl_regs[127:96]}, 0);
    awaddr = 6'hC; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    @(negedge clk);
    chk("fresh_commit", {bvalid, bresp, wr_pulse}, {1'b1, 2'b00, 8'h08});
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    axi_rd(6'hC, d0, rr0, d1, rr1);
    chk("fresh_read", {d0, rr0}, {32'h77, 2'b00});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
